// File: rtl/crc_pkg.sv
// crc_pkg: shared types and helpers for the CRC engine.
//   crc_state_e  : engine state (ACCUM collecting beats, HOLD presenting a result)
//   bit_reverse  : mirrors the low 'width' bits of a 32-bit value (upper bits return 0)
package crc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } crc_state_e;

   localparam int unsigned MAX_CRC_W = 32;

   function automatic logic [MAX_CRC_W-1:0] bit_reverse(input logic [MAX_CRC_W-1:0] value,
                                                        input int unsigned         width);
      logic [MAX_CRC_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_CRC_W; i++) begin
         if (i < int'(width)) begin
            r[i] = value[int'(width) - 1 - i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step: combinational single-byte CRC update.
// Ports:
//   acc_in  [CRC_W-1:0] : accumulator before this byte
//   data    [7:0]       : byte to fold in (bit-reversed first when REFIN=1)
//   acc_out [CRC_W-1:0] : accumulator after an MSB-first shift-XOR against POLY
module crc_byte_step
   import crc_pkg::*;
#(
   parameter int unsigned       CRC_W = 16,
   parameter logic [CRC_W-1:0]  POLY  = 'h8005,
   parameter bit                REFIN = 1'b0
) (
   input  logic [CRC_W-1:0] acc_in,
   input  logic [7:0]       data,
   output logic [CRC_W-1:0] acc_out
);

   logic [7:0]       din;
   logic [CRC_W-1:0] c;
   logic             fb;

   always_comb begin
      din = data;
      if (REFIN) begin
         din = 8'(bit_reverse({24'd0, data}, 32'd8));
      end
      c  = acc_in;
      fb = 1'b0;
      for (int b = 7; b >= 0; b--) begin
         fb = c[CRC_W-1] ^ din[b];
         c  = {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY);
      end
      acc_out = c;
   end

endmodule

// File: rtl/crc_engine.sv
// crc_engine: streaming CRC over byte-enabled beats with a held result.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   s_valid/s_ready     : input beat handshake
//   s_data, s_keep      : beat bytes (byte i = s_data[8i+7:8i]) and per-byte enables
//   s_last              : final beat of the frame
//   abort               : drop the frame being accumulated (ignored while holding a result)
//   m_valid/m_ready     : result handshake
//   m_crc, m_len        : final CRC and saturating byte count of the frame
//
// state | meaning
// ACCUM | accepting beats, folding enabled bytes into acc
// HOLD  | result presented on m_crc/m_len until m_ready
module crc_engine
   import crc_pkg::*;
#(
   parameter int unsigned       CRC_W      = 16,
   parameter logic [CRC_W-1:0]  POLY       = 'h8005,
   parameter logic [CRC_W-1:0]  INIT       = 'h0000,
   parameter logic [CRC_W-1:0]  XOROUT     = 'h0000,
   parameter bit                REFIN      = 1'b0,
   parameter bit                REFOUT     = 1'b0,
   parameter int unsigned       DATA_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [8*DATA_BYTES-1:0] s_data,
   input  logic [DATA_BYTES-1:0]   s_keep,
   input  logic                    s_last,
   input  logic                    abort,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [CRC_W-1:0]        m_crc,
   output logic [15:0]             m_len
);

   crc_state_e        state, state_nxt;
   logic [CRC_W-1:0]  acc;
   logic [15:0]       count;
   logic [CRC_W-1:0]  m_crc_q;
   logic [15:0]       m_len_q;

   logic [CRC_W-1:0]  chain    [DATA_BYTES+1];
   logic [CRC_W-1:0]  step_out [DATA_BYTES];
   logic [CRC_W-1:0]  acc_next;
   logic [31:0]       crc_ext;
   logic [CRC_W-1:0]  crc_final;
   logic [3:0]        keep_cnt;
   logic [16:0]       len_sum;
   logic [15:0]       len_next;
   logic              accept;

   // Byte lanes chained in ascending order; a disabled lane passes the accumulator through.
   assign chain[0] = acc;
   for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
      crc_byte_step #(
         .CRC_W (CRC_W),
         .POLY  (POLY),
         .REFIN (REFIN)
      ) u_step (
         .acc_in  (chain[i]),
         .data    (s_data[8*i +: 8]),
         .acc_out (step_out[i])
      );
      assign chain[i+1] = s_keep[i] ? step_out[i] : chain[i];
   end
   assign acc_next = chain[DATA_BYTES];

   always_comb begin
      crc_ext = '0;
      crc_ext[CRC_W-1:0] = acc_next;
      crc_final = acc_next;
      if (REFOUT) begin
         crc_final = CRC_W'(bit_reverse(crc_ext, CRC_W));
      end
      crc_final = crc_final ^ XOROUT;
   end

   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         keep_cnt = keep_cnt + 4'(s_keep[i]);
      end
      len_sum  = {1'b0, count} + {13'd0, keep_cnt};
      len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
   end

   // Handshake outputs depend only on registered state (and rst), never on s_valid/m_ready.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      case (state)
         ACCUM: begin
            s_ready = ~rst;
            if (s_valid && s_ready && !abort && s_last) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            m_valid = 1'b1;
            if (m_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   assign accept = s_valid & s_ready;

   // acc/count are cleared on entry to HOLD so the return to ACCUM starts a fresh frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ACCUM;
         acc     <= INIT;
         count   <= '0;
         m_crc_q <= '0;
         m_len_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == ACCUM) begin
            if (abort) begin
               acc   <= INIT;
               count <= '0;
            end else if (accept) begin
               if (s_last) begin
                  m_crc_q <= crc_final;
                  m_len_q <= len_next;
                  acc     <= INIT;
                  count   <= '0;
               end else begin
                  acc   <= acc_next;
                  count <= len_next;
               end
            end
         end
      end
   end

   assign m_crc = m_crc_q;
   assign m_len = m_len_q;

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: table-driven frames with a scoreboard, plus hand sequences for
// abort, result stall, reset mid-frame / in HOLD, and a CRC-32 configuration.
module tb_crc_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_last, abort, m_ready;
   logic [15:0] s_data;
   logic [1:0]  s_keep;

   logic        s_ready0, s_ready1, s_ready2;
   logic        m_valid0, m_valid1, m_valid2;
   logic [15:0] m_crc0, m_crc1, m_crc2;
   logic [15:0] m_len0, m_len1, m_len2;

   logic        v32, rdy32, l32, abort32, mready32, mv32;
   logic [31:0] d32, crc32;
   logic [3:0]  k32;
   logic [15:0] len32;

   always #5 clk = ~clk;

   crc_engine u0 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .abort(abort), .m_valid(m_valid0),
      .m_ready(m_ready), .m_crc(m_crc0), .m_len(m_len0));

   crc_engine #(.REFIN(1'b1), .REFOUT(1'b1)) u1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .abort(abort), .m_valid(m_valid1),
      .m_ready(m_ready), .m_crc(m_crc1), .m_len(m_len1));

   crc_engine #(.POLY(16'h1021), .INIT(16'hFFFF)) u2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .abort(abort), .m_valid(m_valid2),
      .m_ready(m_ready), .m_crc(m_crc2), .m_len(m_len2));

   crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
                .REFIN(1'b1), .REFOUT(1'b1), .DATA_BYTES(4)) u3 (
      .clk(clk), .rst(rst), .s_valid(v32), .s_ready(rdy32), .s_data(d32),
      .s_keep(k32), .s_last(l32), .abort(abort32), .m_valid(mv32),
      .m_ready(mready32), .m_crc(crc32), .m_len(len32));

   typedef struct packed {
      logic [15:0] c0, c1, c2, len;
   } exp_t;

   typedef struct packed {
      int               nbeats;
      logic [0:5][15:0] data;
      logic [0:5][1:0]  keep;
      logic [15:0]      e0, e1, e2, len;
      bit               has_const;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   results = 0;
   int   expected_results = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

   // Textbook byte-at-a-time CRC-16; the reflected form shifts right with a mirrored poly.
   function automatic logic [15:0] model16(input logic [7:0] q[$], input logic [15:0] poly,
                                           input logic [15:0] init, input bit refl);
      logic [15:0] c, rp;
      rp = rev16(poly);
      c  = refl ? rev16(init) : init;
      foreach (q[i]) begin
         if (refl) begin
            c = c ^ {8'h00, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
         end else begin
            c = c ^ {q[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ poly) : (c << 1);
         end
      end
      return c;
   endfunction

   // Result monitor: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (!rst && m_valid0 && m_ready) begin
         results++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%h required=none", m_crc0);
         end else begin
            mon_e = sb.pop_front();
            check("crc_default", {16'd0, m_crc0}, {16'd0, mon_e.c0});
            check("crc_reflected", {16'd0, m_crc1}, {16'd0, mon_e.c1});
            check("crc_ccitt", {16'd0, m_crc2}, {16'd0, mon_e.c2});
            check("len", {16'd0, m_len0}, {16'd0, mon_e.len});
            check("valid_siblings", {30'd0, m_valid1, m_valid2}, 32'd3);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l,
                            output bit ok);
      s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (s_ready0) ok = 1'b1;
         step();
      end
      s_valid = 1'b0; s_last = 1'b0; s_keep = 2'b00;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] q[$];
      exp_t       e;
      bit         ok;
      for (int b = 0; b < v.nbeats; b++)
         for (int k = 0; k < 2; k++)
            if (v.keep[b][k]) q.push_back(v.data[b][8*k +: 8]);
      if (v.has_const) begin
         e = '{c0: v.e0, c1: v.e1, c2: v.e2, len: v.len};
      end else begin
         e.c0  = model16(q, 16'h8005, 16'h0000, 1'b0);
         e.c1  = model16(q, 16'h8005, 16'h0000, 1'b1);
         e.c2  = model16(q, 16'h1021, 16'hFFFF, 1'b0);
         e.len = v.len;
      end
      sb.push_back(e);
      expected_results++;
      for (int b = 0; b < v.nbeats; b++) begin
         repeat ($urandom_range(0, 1)) step();
         send_beat(v.data[b], v.keep[b], (b == v.nbeats - 1), ok);
         if (ok && b == v.nbeats - 1) check("latency_valid", {31'd0, m_valid0}, 32'd1);
         else if (ok) check("no_early_valid", {31'd0, m_valid0}, 32'd0);
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) step();
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      end
   endtask

   task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit ok;
      v32 = 1'b1; d32 = d; k32 = k; l32 = l; ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (rdy32) ok = 1'b1;
         step();
      end
      v32 = 1'b0; l32 = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL beat32_timeout actual=no_accept required=accept");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      vecs[0] = '{nbeats: 5, data: {16'h3231, 16'h3433, 16'h3635, 16'h3837, 16'h0039, 16'h0000},
                  keep: {2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0},
                  e0: 16'hFEE8, e1: 16'hBB3D, e2: 16'h29B1, len: 16'd9, has_const: 1'b1};
      vecs[1] = '{nbeats: 1, data: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                  keep: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                  e0: 16'h0000, e1: 16'h0000, e2: 16'hFFFF, len: 16'd0, has_const: 1'b1};
      vecs[2] = '{nbeats: 4, data: {16'h3231, 16'h3433, 16'hABCD, 16'h0000, 16'h0000, 16'h0000},
                  keep: {2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0},
                  e0: 16'h0, e1: 16'h0, e2: 16'h0, len: 16'd4, has_const: 1'b0};
      vecs[3] = '{nbeats: 1, data: {16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                  keep: {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                  e0: 16'h0, e1: 16'h0, e2: 16'h0, len: 16'd1, has_const: 1'b0};
      vecs[4] = '{nbeats: 6, data: {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C},
                  keep: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3},
                  e0: 16'h0, e1: 16'h0, e2: 16'h0, len: 16'd12, has_const: 1'b0};
      vecs[5] = '{nbeats: 6, data: {16'h0031, 16'h3332, 16'h3400, 16'h3635, 16'h3837, 16'h0039},
                  keep: {2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd1},
                  e0: 16'hFEE8, e1: 16'hBB3D, e2: 16'h29B1, len: 16'd9, has_const: 1'b1};

      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; abort = 1'b0; m_ready = 1'b1;
      s_data = '0; s_keep = '0;
      v32 = 1'b0; l32 = 1'b0; d32 = '0; k32 = '0; abort32 = 1'b0; mready32 = 1'b1;

      // Reset state
      repeat (3) step();
      @(negedge clk);
      check("rst_ready_low", {31'd0, s_ready0}, 32'd0);
      check("rst_valid", {31'd0, m_valid0}, 32'd0);
      check("rst_crc", {16'd0, m_crc0}, 32'd0);
      check("rst_len", {16'd0, m_len0}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'd0, s_ready0}, 32'd1);
      step();

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         wait_drain();
      end

      // Abort together with a last beat mid-frame: dropped, then a clean frame
      send_beat(16'h3231, 2'd3, 1'b0, ok);
      abort = 1'b1;
      send_beat(16'h3433, 2'd3, 1'b1, ok);
      abort = 1'b0;
      check("abort_no_result", {31'd0, m_valid0}, 32'd0);
      run_vec(vecs[0]);
      wait_drain();

      // Result stall with abort pulsed in HOLD
      m_ready = 1'b0;
      run_vec(vecs[0]);
      for (int c = 0; c < 10; c++) begin
         abort = (c == 4);
         @(negedge clk);
         check("hold_valid", {31'd0, m_valid0}, 32'd1);
         check("hold_ready", {31'd0, s_ready0}, 32'd0);
         check("hold_crc", {16'd0, m_crc0}, 32'h0000FEE8);
         check("hold_len", {16'd0, m_len0}, 32'd9);
         step();
      end
      abort = 1'b0;
      m_ready = 1'b1;
      wait_drain();

      // Reset mid-frame
      send_beat(16'h3231, 2'd3, 1'b0, ok);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready_low", {31'd0, s_ready0}, 32'd0);
      step();
      check("midrst_crc", {16'd0, m_crc0}, 32'd0);
      check("midrst_valid", {31'd0, m_valid0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ready_high", {31'd0, s_ready0}, 32'd1);
      step();
      run_vec(vecs[0]);
      wait_drain();

      // Reset while holding a result discards it
      m_ready = 1'b0;
      run_vec(vecs[4]);
      step();
      rst = 1'b1;
      void'(sb.pop_back());
      expected_results--;
      step();
      rst = 1'b0;
      check("holdrst_valid", {31'd0, m_valid0}, 32'd0);
      check("holdrst_len", {16'd0, m_len0}, 32'd0);
      m_ready = 1'b1;
      run_vec(vecs[2]);
      wait_drain();

      // CRC-32 configuration, 4 bytes per beat
      send32(32'h34333231, 4'hF, 1'b0);
      send32(32'h38373635, 4'hF, 1'b0);
      send32(32'h00000039, 4'h1, 1'b1);
      check("crc32_valid", {31'd0, mv32}, 32'd1);
      check("crc32_value", crc32, 32'hCBF43926);
      check("crc32_len", {16'd0, len32}, 32'd9);
      repeat (3) step();

      check("sb_empty", sb.size(), 32'd0);
      check("result_count", results, expected_results);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16, CRC width in bits; legal range 8..32.
REQ-002 SHALL have parameter POLY, default 'h8005, generator polynomial with the implicit top bit omitted; CRC_W bits.
REQ-003 SHALL have parameter INIT, default 'h0000, accumulator start value; CRC_W bits.
REQ-004 SHALL have parameter XOROUT, default 'h0000, final XOR mask; CRC_W bits.
REQ-005 SHALL have parameters REFIN and REFOUT, default 0 each, for per-byte input reflection and whole-result output reflection.
REQ-006 SHALL have parameter DATA_BYTES, default 2, bytes per input beat; legal range 1..8.
REQ-007 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-008 Port clk: input, 1 bit, rising-edge clock.
REQ-009 Port rst: input, 1 bit, synchronous active-high reset.
REQ-010 Port s_valid: input, 1 bit, input beat valid.
REQ-011 Port s_ready: output, 1 bit, engine accepts a beat.
REQ-012 Port s_data: input, 8*DATA_BYTES bits; byte i is s_data[8i+7:8i].
REQ-013 Port s_keep: input, DATA_BYTES bits; byte i is processed when s_keep[i]=1.
REQ-014 Port s_last: input, 1 bit, final beat of the frame.
REQ-015 Port abort: input, 1 bit, discards the current frame.
REQ-016 Port m_valid: output, 1 bit, result valid.
REQ-017 Port m_ready: input, 1 bit, result consumed.
REQ-018 Port m_crc: output, CRC_W bits, final CRC.
REQ-019 Port m_len: output, 16 bits, processed byte count of the frame.

Function
REQ-020 The FSM SHALL have two states: ACCUM (s_ready=1, m_valid=0) and HOLD (s_ready=0, m_valid=1).
REQ-021 A beat is accepted on a clk edge where s_valid and s_ready are both 1; no other beat SHALL change state.
REQ-022 On an accepted beat, enabled bytes SHALL update the accumulator in ascending byte index; disabled bytes are skipped with no effect.
REQ-023 Per-byte update: with REFIN=0, MSB-first shift-XOR against POLY; with REFIN=1, the byte is bit-reversed before the same update.
REQ-024 An accepted beat SHALL add popcount(s_keep) to the length counter, which saturates at 16'hFFFF.
REQ-025 An accepted beat with s_last=1 SHALL move ACCUM to HOLD.
REQ-026 On entering HOLD, m_crc SHALL load (REFOUT ? reverse(acc) : acc) ^ XOROUT, including the last beat's bytes, and m_len SHALL load the final count.
REQ-027 Latency: m_valid SHALL rise on the cycle after the last beat is accepted.
REQ-028 In HOLD, m_valid, m_crc and m_len SHALL stay stable until m_valid and m_ready are both 1.
REQ-029 On that handshake, the FSM SHALL return to ACCUM with acc=INIT and count=0; s_ready is 1 the next cycle (minimum 1 bubble cycle per frame).
REQ-030 A last beat with s_keep=0 SHALL close the frame without adding data.
REQ-031 A zero-length frame SHALL yield (REFOUT ? reverse(INIT) : INIT) ^ XOROUT with m_len=0.
REQ-032 Abort in ACCUM SHALL reset acc to INIT and count to 0; abort takes priority over a simultaneous beat, which is dropped and yields no result.
REQ-033 Abort in HOLD SHALL be ignored; the held result is preserved.
REQ-034 A non-contiguous s_keep is legal; only the set bits count.

Reset
REQ-035 While rst=1 at a clk edge, the block SHALL enter ACCUM with acc=INIT, count=0, m_valid=0, m_crc=0 and m_len=0.
REQ-036 s_ready SHALL be 0 while rst is high and 1 on the first cycle after rst falls.
REQ-037 Reset mid-frame or in HOLD SHALL discard all partial state and any pending result.

Structure
REQ-038 Package crc_pkg SHALL hold the state enum crc_state_e {ACCUM, HOLD} and a bit-reverse function.
REQ-039 Sub-module crc_byte_step (combinational) SHALL compute one byte update (acc, byte, POLY, REFIN -> acc'); crc_engine SHALL instantiate it DATA_BYTES times in a chain, muxed by s_keep.
REQ-040 crc_engine SHALL contain no combinational path from s_valid to s_ready, or from m_ready to m_valid.

Verification
REQ-041 Defaults, "123456789" over 5 beats (last beat keep=01) -> m_crc=16'hFEE8, m_len=9, m_valid one cycle after the last beat.
REQ-042 REFIN=REFOUT=1, other settings default, same data -> m_crc=16'hBB3D; POLY='h1021 with INIT='hFFFF, no reflection -> 16'h29B1.
REQ-043 CRC_W=32, POLY='h04C11DB7, INIT=XOROUT='hFFFFFFFF, REFIN=REFOUT=1, DATA_BYTES=4, same data -> 32'hCBF43926, m_len=9.
REQ-044 Single beat with s_last=1 and keep=0 (defaults) -> m_crc=16'h0000, m_len=0.
REQ-045 Abort asserted with a beat mid-frame, then a clean "123456789" -> one result only, 16'hFEE8.
REQ-046 Hold m_ready=0 for 10 cycles with abort pulsed in HOLD -> result stable, s_ready=0 throughout; rst mid-frame -> next frame computes correctly.
